// File: rtl/input_event_params.sv
// Shared constants for the input event block: default timing for the 25 MHz logic clock,
// player-channel indices, the repeat phase type and small helper functions.
package input_event_params;

    localparam int unsigned DB_CYCLES_DEF  = 32'd16;
    localparam int unsigned RPT_DELAY_DEF  = 32'd2000000;
    localparam int unsigned RPT_PERIOD_DEF = 32'd500000;

    localparam int unsigned CH_LEFT  = 32'd0;
    localparam int unsigned CH_DOWN  = 32'd1;
    localparam int unsigned CH_UP    = 32'd2;
    localparam int unsigned CH_RIGHT = 32'd3;
    localparam int unsigned CH_ENTER = 32'd4;

    localparam logic [4:0] FIRST_NONE = 5'd16;

    typedef enum logic {
        RPT_FIRST = 1'b0,
        RPT_NEXT  = 1'b1
    } rpt_phase_e;

    // Raw line to "pressed" polarity.
    function automatic logic pressed_level(input logic raw_bit, input logic active_low);
        return raw_bit ^ active_low;
    endfunction

    // Index of the lowest set bit, FIRST_NONE when the vector is empty.
    function automatic logic [4:0] first_set16(input logic [15:0] vec);
        logic [4:0] res;
        res = FIRST_NONE;
        for (int i = 15; i >= 0; i--) begin
            res = vec[i] ? 5'(i) : res;
        end
        return res;
    endfunction

endpackage

// File: rtl/input_event_chan.sv
// One input channel: two-flop synchroniser, debounce, press-edge pulse and, when
// INPUT_EVENT_REPEAT_EN is defined, hold auto-repeat pulses.
module input_event_chan
    import input_event_params::*;
#(
    parameter int ACTIVE_LOW = 0,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
`ifdef INPUT_EVENT_REPEAT_EN
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF,
`endif
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_i,
    output logic level_o,
    output logic ev_o
);

    localparam logic             INV     = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             rise_s;

    // Synchroniser; resets to not-pressed regardless of input polarity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pressed_level(raw_i, INV);
            sync2_q <= sync1_q;
        end
    end

    // Debounce: any sample equal to the current level restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                level_d  = level_q;
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Debounced level and its counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign rise_s  = ~level_q & level_d;
    assign level_o = level_q;

`ifdef INPUT_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);

    rpt_phase_e       rpt_ph_q;
    rpt_phase_e       rpt_ph_d;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic [CNT_W-1:0] rpt_last_s;
    logic             fall_s;
    logic             rpt_ev_s;

    assign fall_s = level_q & ~level_d;

    // Repeat timer: a release suppresses a repeat that would land on the same edge.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_ph_d  = rpt_ph_q;
        rpt_ev_s  = 1'b0;
        case (rpt_ph_q)
            RPT_FIRST: rpt_last_s = DELAY_LAST;
            RPT_NEXT:  rpt_last_s = PERIOD_LAST;
            default:   rpt_last_s = DELAY_LAST;
        endcase
        if (rise_s || fall_s || !level_q) begin
            rpt_cnt_d = '0;
            rpt_ph_d  = RPT_FIRST;
        end else if (rpt_cnt_q == rpt_last_s) begin
            rpt_ev_s  = 1'b1;
            rpt_cnt_d = '0;
            rpt_ph_d  = RPT_NEXT;
        end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            rpt_ph_d  = rpt_ph_q;
        end
    end

    // Repeat counter and phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_cnt_q <= '0;
            rpt_ph_q  <= RPT_FIRST;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_ph_q  <= rpt_ph_d;
        end
    end

    assign ev_o = rise_s | rpt_ev_s;
`else
    assign ev_o = rise_s;
`endif

endmodule

// File: rtl/input_event_n.sv
// N-channel key/button event processor: per-channel conditioning, pending vector,
// round-robin arbiter and valid/ready output register. Auto-repeat via INPUT_EVENT_REPEAT_EN.
module input_event_n
    import input_event_params::*;
#(
    parameter int N          = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF,
    parameter int CNT_W      = 32,
    parameter int ID_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    raw,
    output logic [N-1:0]    level,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

    if (N < 1 || N > 16 || DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1 || CNT_W < 1)
    begin : g_bad_params
        $error("input_event_n: illegal parameter set");
    end

    logic [N-1:0]    ev_s;
    logic [N-1:0]    pending_q;
    logic [N-1:0]    pending_d;
    logic [N-1:0]    gnt_oh_s;
    logic [15:0]     all16_s;
    logic [15:0]     hi16_s;
    logic [4:0]      lo_first_s;
    logic [4:0]      hi_first_s;
    logic            gnt_found_s;
    logic [ID_W-1:0] gnt_idx_s;
    logic            load_s;
    logic            take_s;
    logic            ovf_set_s;
    logic            evt_valid_q;
    logic            evt_valid_d;
    logic [ID_W-1:0] evt_id_q;
    logic [ID_W-1:0] evt_id_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic            overflow_q;
    logic            overflow_d;

    for (genvar g = 0; g < N; g++) begin : g_chan
        input_event_chan #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DB_CYCLES  (DB_CYCLES),
`ifdef INPUT_EVENT_REPEAT_EN
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
`endif
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .raw_i   (raw[g]),
            .level_o (level[g]),
            .ev_o    (ev_s[g])
        );
    end

    // Round-robin search: lowest pending index at or after rr_ptr, else lowest overall.
    always_comb begin
        all16_s = 16'(pending_q);
        hi16_s  = 16'h0000;
        for (int i = 0; i < N; i++) begin
            hi16_s[i] = pending_q[i] & (ID_W'(i) >= rr_ptr_q);
        end
        lo_first_s  = first_set16(all16_s);
        hi_first_s  = first_set16(hi16_s);
        gnt_found_s = (lo_first_s != FIRST_NONE);
        gnt_idx_s   = (hi_first_s != FIRST_NONE) ? hi_first_s[ID_W-1:0] : lo_first_s[ID_W-1:0];
    end

    assign load_s = ~evt_valid_q | evt_ready;
    assign take_s = load_s & gnt_found_s;

    // Pending update; a grant on the same edge frees the slot for the new event.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gnt_oh_s[i] = take_s & (gnt_idx_s == ID_W'(i));
        end
        pending_d  = ev_s | (pending_q & ~gnt_oh_s);
        ovf_set_s  = |(ev_s & pending_q & ~gnt_oh_s);
        overflow_d = ovf_set_s | (overflow_q & ~clr_overflow);
    end

    // Output register next state; holds steady while stalled.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s) begin
            evt_valid_d = gnt_found_s;
            if (gnt_found_s) begin
                evt_id_d = gnt_idx_s;
                rr_ptr_d = (gnt_idx_s == LAST_ID) ? '0 : gnt_idx_s + ID_W'(1);
            end else begin
                evt_id_d = evt_id_q;
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // Arbiter, output and status state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_input_event_n.sv
// Directed bench for input_event_n (N=4, DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8),
// plus an ACTIVE_LOW instance for the reset-mid-hold scenario.
module tb_input_event_n;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int CW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rstn_al;
    logic [N-1:0]  raw;
    logic [N-1:0]  raw_al;
    logic          evt_ready;
    logic          evt_ready_al;
    logic          clr_overflow;
    logic          clr_overflow_al;
    logic [N-1:0]  level;
    logic [N-1:0]  level_al;
    logic          evt_valid;
    logic          evt_valid_al;
    logic [IW-1:0] evt_id;
    logic [IW-1:0] evt_id_al;
    logic          overflow;
    logic          overflow_al;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_event_n #(.N(N), .ACTIVE_LOW(0), .DB_CYCLES(DB), .RPT_DELAY(RD),
                    .RPT_PERIOD(RP), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .raw(raw), .level(level), .evt_valid(evt_valid),
        .evt_id(evt_id), .evt_ready(evt_ready), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    input_event_n #(.N(N), .ACTIVE_LOW(1), .DB_CYCLES(DB), .RPT_DELAY(RD),
                    .RPT_PERIOD(RP), .CNT_W(CW)) dut_al (
        .clk(clk), .rstn(rstn_al), .raw(raw_al), .level(level_al), .evt_valid(evt_valid_al),
        .evt_id(evt_id_al), .evt_ready(evt_ready_al), .overflow(overflow_al),
        .clr_overflow(clr_overflow_al)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; rstn_al = 1'b0;
        raw = 4'h0; raw_al = 4'hF;
        evt_ready = 1'b1; evt_ready_al = 1'b1;
        clr_overflow = 1'b0; clr_overflow_al = 1'b0;
        #2;
        checks++;
        if ({level, evt_valid, evt_id, overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %h expected 00", {level, evt_valid, evt_id, overflow});
        end
        tick(2);
        rstn = 1'b1; rstn_al = 1'b1;
        tick(10);
        checks++;
        if ({level, evt_valid, level_al, evt_valid_al} !== 10'h000) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 000",
                     {level, evt_valid, level_al, evt_valid_al});
        end
    endtask

    task automatic test_glitch;
        raw[1] = 1'b1;
        tick(3);
        raw[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (level[1] !== 1'b0 || evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject: level1=%b valid=%b expected 0 0", level[1], evt_valid);
            end
        end
        raw[1] = 1'b1;
        tick(5);
        checks++;
        if (level[1] !== 1'b0) begin
            errors++;
            $display("FAIL db_edge4: level1=%b expected 0", level[1]);
        end
        tick(1);
        checks++;
        if (level[1] !== 1'b1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL db_edge5: level1=%b valid=%b expected 1 0", level[1], evt_valid);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            errors++;
            $display("FAIL press_evt: valid=%b id=%0d expected 1 1", evt_valid, evt_id);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_evt: valid=%b expected 0", evt_valid);
        end
        tick(2);
        raw[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL release_no_evt: valid=%b expected 0", evt_valid);
            end
        end
        checks++;
        if (level[1] !== 1'b0) begin
            errors++;
            $display("FAIL release_level: level1=%b expected 0", level[1]);
        end
    endtask

    task automatic test_round_robin;
        raw = 4'b1001;
        tick(6);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_early: valid=%b expected 0", evt_valid);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_first3: valid=%b id=%0d expected 1 3", evt_valid, evt_id);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rr_then0: valid=%b id=%0d expected 1 0", evt_valid, evt_id);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: valid=%b expected 0", evt_valid);
        end
        raw = 4'b0000;
        tick(8);
        raw = 4'b1000;
        tick(7);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_solo3: valid=%b id=%0d expected 1 3", evt_valid, evt_id);
        end
        raw = 4'b0000;
        tick(8);
        raw = 4'b0011;
        tick(7);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rr_first0: valid=%b id=%0d expected 1 0", evt_valid, evt_id);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            errors++;
            $display("FAIL rr_then1: valid=%b id=%0d expected 1 1", evt_valid, evt_id);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain2: valid=%b expected 0", evt_valid);
        end
        raw = 4'b0000;
        tick(8);
    endtask

    task automatic test_repeat;
        int got[16];
        int ngot;
`ifdef INPUT_EVENT_REPEAT_EN
        int exp_off[6] = '{0, 20, 28, 36, 44, 52};
        int nexp = 6;
`else
        int exp_off[1] = '{0};
        int nexp = 1;
`endif
        ngot = 0;
        raw[2] = 1'b1;
        for (int j = 0; j <= 110; j++) begin
            tick(1);
            if (evt_valid === 1'b1) begin
                if (ngot < 16) got[ngot] = j - 6;
                ngot++;
                checks++;
                if (evt_id !== 2'd2) begin
                    errors++;
                    $display("FAIL rpt_id: id=%0d expected 2", evt_id);
                end
            end
            if (j == 55) raw[2] = 1'b0;
        end
        checks++;
        if (ngot !== nexp) begin
            errors++;
            $display("FAIL rpt_count: got %0d events expected %0d", ngot, nexp);
        end
        for (int k = 0; k < nexp; k++) begin
            if (k < ngot && k < 16) begin
                checks++;
                if (got[k] !== exp_off[k]) begin
                    errors++;
                    $display("FAIL rpt_offset%0d: got %0d expected %0d", k, got[k], exp_off[k]);
                end
            end
        end
        checks++;
        if (level[2] !== 1'b0) begin
            errors++;
            $display("FAIL rpt_release_level: level2=%b expected 0", level[2]);
        end
    endtask

    task automatic test_overflow;
        evt_ready = 1'b0;
        raw[0] = 1'b1;
        tick(7);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_first: valid=%b id=%0d expected 1 0", evt_valid, evt_id);
        end
        raw[0] = 1'b0;
        tick(8);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || level[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b id=%0d level0=%b expected 1 0 0", evt_valid, evt_id, level[0]);
        end
        raw[0] = 1'b1;
        tick(6);
        checks++;
        if (dut.pending_q !== 4'b0001 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_pending: pending=%b ovf=%b expected 0001 0", dut.pending_q, overflow);
        end
        raw[0] = 1'b0;
        tick(8);
        raw[0] = 1'b1;
        tick(6);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b expected 1", overflow);
        end
        tick(2);
        checks++;
        if (overflow !== 1'b1 || evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b valid=%b id=%0d expected 1 1 0", overflow, evt_valid, evt_id);
        end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
        evt_ready = 1'b1;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || dut.pending_q !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain: valid=%b id=%0d pending=%b expected 1 0 0000",
                     evt_valid, evt_id, dut.pending_q);
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b expected 0", evt_valid);
        end
        raw[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_active_low;
        raw_al[0] = 1'b0;
        tick(5);
        checks++;
        if (level_al[0] !== 1'b0) begin
            errors++;
            $display("FAIL al_edge4: level0=%b expected 0", level_al[0]);
        end
        tick(1);
        checks++;
        if (level_al[0] !== 1'b1) begin
            errors++;
            $display("FAIL al_level: level0=%b expected 1", level_al[0]);
        end
        tick(1);
        checks++;
        if (evt_valid_al !== 1'b1 || evt_id_al !== 2'd0) begin
            errors++;
            $display("FAIL al_evt: valid=%b id=%0d expected 1 0", evt_valid_al, evt_id_al);
        end
        tick(1);
        checks++;
        if (evt_valid_al !== 1'b0) begin
            errors++;
            $display("FAIL al_single: valid=%b expected 0", evt_valid_al);
        end
        tick(3);
        rstn_al = 1'b0;
        #1;
        checks++;
        if ({level_al, evt_valid_al, evt_id_al, overflow_al} !== 8'h00) begin
            errors++;
            $display("FAIL al_reset_async: got %h expected 00",
                     {level_al, evt_valid_al, evt_id_al, overflow_al});
        end
        tick(2);
        rstn_al = 1'b1;
        tick(5);
        checks++;
        if (level_al[0] !== 1'b0) begin
            errors++;
            $display("FAIL al_redb_early: level0=%b expected 0", level_al[0]);
        end
        tick(1);
        checks++;
        if (level_al[0] !== 1'b1) begin
            errors++;
            $display("FAIL al_redb_level: level0=%b expected 1", level_al[0]);
        end
        tick(1);
        checks++;
        if (evt_valid_al !== 1'b1 || evt_id_al !== 2'd0) begin
            errors++;
            $display("FAIL al_fresh_evt: valid=%b id=%0d expected 1 0", evt_valid_al, evt_id_al);
        end
        raw_al[0] = 1'b1;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_round_robin();
        test_repeat();
        test_overflow();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
